// File: rtl/board_scan_reader.sv
`default_nettype none
// ============================================================================
// Module   : board_scan_reader
// Brief    : Walks a 64-square board memory and streams (row, col, piece)
//            tuples over a valid/ready handshake, counting occupied squares.
//            Define SKIP_EMPTY_EN to drop empty squares from the stream.
// Revision : 1.0 - initial release
// ============================================================================
module board_scan_reader #(
  parameter int FLIP = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [5:0] rd_addr,
  input  logic [4:0] rd_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_row,
  output logic [2:0] out_col,
  output logic [4:0] out_piece,
  output logic       out_last,
  output logic       busy,
  output logic       done,
  output logic [6:0] piece_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_READ    = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_EMIT    = 3'd3;
  localparam logic [2:0] S_FINISH  = 3'd4;

  localparam logic [5:0] C_FIRST_SQ = (FLIP != 0) ? 6'd63 : 6'd0;
  localparam logic [5:0] C_LAST_SQ  = (FLIP != 0) ? 6'd0  : 6'd63;

  logic [2:0] state_q, state_d;
  logic [5:0] index_q, index_d;
  logic [6:0] count_q, count_d;
  logic [2:0] row_q, row_d;
  logic [2:0] col_q, col_d;
  logic [4:0] piece_q, piece_d;
  logic       last_q, last_d;

  logic       w_final;
  logic       w_skip;
  logic [5:0] w_next_index;

  assign w_final      = (index_q == C_LAST_SQ);
  assign w_next_index = (FLIP != 0) ? (index_q - 6'd1) : (index_q + 6'd1);

`ifdef SKIP_EMPTY_EN
  assign w_skip = ~rd_data[0];
`else
  assign w_skip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      index_q <= 6'd0;
      count_q <= 7'd0;
      row_q   <= 3'd0;
      col_q   <= 3'd0;
      piece_q <= 5'd0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      count_q <= count_d;
      row_q   <= row_d;
      col_q   <= col_d;
      piece_q <= piece_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    count_d = count_q;
    row_d   = row_q;
    col_d   = col_q;
    piece_d = piece_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          index_d = C_FIRST_SQ;
          count_d = 7'd0;
          state_d = S_READ;
        end
      end
      S_READ: state_d = S_CAPTURE;
      S_CAPTURE: begin
        if (rd_data[0]) begin
          count_d = count_q + 7'd1;
        end
        if (w_skip) begin
          if (w_final) begin
            state_d = S_FINISH;
          end else begin
            index_d = w_next_index;
            state_d = S_READ;
          end
        end else begin
          row_d   = index_q[5:3];
          col_d   = index_q[2:0];
          piece_d = rd_data;
          last_d  = w_final;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        // The final square ends the scan instead of stepping, so the index never wraps.
        if (out_ready) begin
          if (w_final) begin
            state_d = S_FINISH;
          end else begin
            index_d = w_next_index;
            state_d = S_READ;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q == S_EMIT);
    busy      = (state_q == S_READ) || (state_q == S_CAPTURE) || (state_q == S_EMIT);
    done      = (state_q == S_FINISH);
  end

  assign rd_addr     = index_q;
  assign out_row     = row_q;
  assign out_col     = col_q;
  assign out_piece   = piece_q;
  assign out_last    = last_q;
  assign piece_count = count_q;

endmodule
`default_nettype wire
